// File: rtl/mac_vector_engine.sv
// mac_vector_engine: streamed dot-product engine.
// Operand pairs arrive over a valid/ready handshake and pass through a
// 3-stage pipeline (operand register, product register, accumulator).
// Supports unsigned/signed jobs, optional saturation, a sticky overflow
// flag, and a result that is held until the consumer takes it.
module mac_vector_engine #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 12,
    parameter int LEN_W  = 4,
    parameter int SAT    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              signed_mode,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              ovf,
    output logic              busy
);

    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [LEN_W:0]      remaining;   // one extra bit so len=0 can mean 2^LEN_W
    logic                mode_s;      // signed_mode captured at start
    logic [2:1]          vld_pipe;    // [1]: operand stage, [2]: product stage
    logic [DATA_W-1:0]   a_r, b_r;
    logic [PROD_W-1:0]   prod_r;
    logic [ACC_W-1:0]    acc_r;
    logic                ovf_r;

    logic                accept;
    logic                job_start;
    logic [PROD_W-1:0]   ext_a, ext_b, prod_w;
    logic [ACC_W-1:0]    addend;
    logic [ACC_W:0]      sum;
    logic                ovf_add;
    logic [ACC_W-1:0]    sat_val;
    logic [ACC_W-1:0]    acc_nxt;

    assign job_start = (state == IDLE) && start;
    assign accept    = in_valid && in_ready;

    // Handshake/status outputs decoded straight from the state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        if (state == RUN && remaining != '0)
            in_ready = 1'b1;
        if (state == DONE)
            out_valid = 1'b1;
        if (state != IDLE)
            busy = 1'b1;
    end

    assign acc_out = acc_r;
    assign ovf     = ovf_r;

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = RUN;
            end
            RUN: begin
                if (remaining == '0 ||
                    (accept && remaining == (LEN_W+1)'(1)))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                // Nothing new enters in DRAIN, so once the operand stage is
                // empty the product stage empties into the accumulator on
                // this same edge; DONE then coincides with the final sum.
                if (!vld_pipe[1])
                    state_nxt = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Job control: remaining pair count and captured arithmetic mode
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
            mode_s    <= 1'b0;
        end else if (job_start) begin
            remaining <= (len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};
            mode_s    <= signed_mode;
        end else if (accept) begin
            remaining <= remaining - (LEN_W+1)'(1);
        end
    end

    // One multiplier serves both modes: extending the operands to the
    // product width (sign- or zero-) makes the low PROD_W bits correct.
    assign ext_a  = mode_s ? PROD_W'($signed(a_r)) : PROD_W'(a_r);
    assign ext_b  = mode_s ? PROD_W'($signed(b_r)) : PROD_W'(b_r);
    assign prod_w = ext_a * ext_b;

    // Pipeline stages 1 (operands) and 2 (product) with their valid bits
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            a_r      <= '0;
            b_r      <= '0;
            prod_r   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1], accept};
            if (accept) begin
                a_r <= in_a;
                b_r <= in_b;
            end
            if (vld_pipe[1])
                prod_r <= prod_w;
        end
    end

    // Accumulate: widen the product, add at ACC_W+1 bits, detect overflow,
    // optionally clamp.
    always_comb begin
        addend  = mode_s ? ACC_W'($signed(prod_r)) : ACC_W'(prod_r);
        sum     = {1'b0, acc_r} + {1'b0, addend};
        ovf_add = 1'b0;
        sat_val = {ACC_W{1'b1}};
        if (mode_s) begin
            ovf_add = (acc_r[ACC_W-1] == addend[ACC_W-1]) &&
                      (sum[ACC_W-1] != acc_r[ACC_W-1]);
            // Signed overflow direction follows the common addend sign
            sat_val = acc_r[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            ovf_add = sum[ACC_W];
        end
        acc_nxt = (ovf_add && SAT != 0) ? sat_val : sum[ACC_W-1:0];
    end

    // Stage 3: accumulator and sticky overflow; cleared only by start
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= '0;
            ovf_r <= 1'b0;
        end else if (job_start) begin
            acc_r <= '0;
            ovf_r <= 1'b0;
        end else if (vld_pipe[2]) begin
            acc_r <= acc_nxt;
            ovf_r <= ovf_r | ovf_add;
        end
    end

endmodule
